mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between a fetch port and a load/store port.
// Optional fetch starvation guard enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   force_i;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    force_i  = i_req && (starve_q == CNT_MAX);
    starve_d = starve_q;
    if (i_gnt) begin
      starve_d = '0;
    end else if (i_req && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Data side wins unless the starvation guard is forcing a fetch grant.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !force_i) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else begin
        i_gnt = 1'b0;
      end
    end else begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = d_gnt ? d_addr : i_addr;
    mem_wdata = d_wdata;
  end

  // Track which port owns the read returning next cycle; stores leave nothing outstanding.
  always_comb begin
    if (i_gnt) begin
      state_d = RD_I;
    end else if (d_gnt && !d_we) begin
      state_d = RD_D;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset suppresses a response that was still in flight when it arrived.
  assign i_rvalid = (state_q == RD_I) && !reset;
  assign d_rvalid = (state_q == RD_D) && !reset;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literal checks.
// Honours MEM_ARBITER_STARVE_GUARD_EN the same way as the design.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [9:0]  i_addr = 10'd0;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [9:0]  d_addr = 10'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment and an independent reference copy for the model.
  logic [31:0] mem [0:1023];
  logic [31:0] model_mem [0:1023];
  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem[k]       = 32'h5A000000 | 32'(k);
      model_mem[k] = 32'h5A000000 | 32'(k);
    end
    mem[16]       = 32'hDEADBEEF;
    model_mem[16] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Model: who owns this cycle, and which response is due next cycle.
  int          exp_pend = 0;  // 0 none, 1 fetch, 2 data
  logic [31:0] exp_data = 32'd0;
  int          starve = 0;

  function automatic int owner();
    if (reset) return 0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    if (i_req && starve >= STARVE_MAX) return 1;
`endif
    if (d_req) return 2;
    if (i_req) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int o;
    o = owner();
    if (reset) begin
      exp_pend = 0;
      starve   = 0;
    end else begin
      exp_pend = 0;
      if (o == 2 && d_we) begin
        model_mem[d_addr] = d_wdata;
      end else if (o == 2) begin
        exp_pend = 2;
        exp_data = model_mem[d_addr];
      end else if (o == 1) begin
        exp_pend = 1;
        exp_data = model_mem[i_addr];
      end
      if (o == 1) starve = 0;
      else if (i_req && starve < STARVE_MAX) starve = starve + 1;
    end
  end

  always @(negedge clk) begin
    int o;
    o = owner();
    chk("i_gnt", 32'(i_gnt), 32'(o == 1));
    chk("d_gnt", 32'(d_gnt), 32'(o == 2));
    chk("mem_en", 32'(mem_en), 32'(o != 0));
    chk("mem_we", 32'(mem_we), 32'(o == 2 && d_we));
    if (o != 0) chk("mem_addr", 32'(mem_addr), 32'((o == 2) ? d_addr : i_addr));
    if (o == 2 && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    chk("i_rvalid", 32'(i_rvalid), 32'(exp_pend == 1 && !reset));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_pend == 2 && !reset));
    if (exp_pend == 1 && !reset) chk("i_rdata", i_rdata, exp_data);
    if (exp_pend == 2 && !reset) chk("d_rdata", d_rdata, exp_data);
  end

  task automatic cyc(input logic rs, input logic ir, input logic [9:0] ia,
                     input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    reset = rs; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] ig;
    int          nv, ni, nd;

    // Reset with both requesters active: nothing may be granted.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'd0);
      chk("rst_gnt", 32'({i_gnt, d_gnt, mem_en, mem_we}), 32'd0);
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    end

    // Single fetch.
    cyc(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("fetch_gnt", 32'({i_gnt, d_gnt}), 32'b10);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("fetch_rvalid", 32'({i_rvalid, d_rvalid}), 32'b10);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);

    // Simultaneous fetch and load: data first, fetch next, back to back.
    cyc(1'b0, 1'b1, 10'h011, 1'b1, 1'b0, 10'h020, 32'd0);
    chk("both_gnt", 32'({i_gnt, d_gnt}), 32'b01);
    cyc(1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("both_gnt2", 32'({i_gnt, d_rvalid}), 32'b11);
    chk("both_drdata", d_rdata, 32'h5A000020);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("both_irvalid", 32'({i_rvalid, d_rvalid}), 32'b10);
    chk("both_irdata", i_rdata, 32'h5A000011);

    // Store then load of the same word.
    cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h005, 32'h12345678);
    chk("st_we", 32'({d_gnt, mem_we}), 32'b11);
    cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h005, 32'd0);
    chk("ld_we", 32'({d_gnt, mem_we, d_rvalid}), 32'b100);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("ld_rvalid", 32'(d_rvalid), 32'd1);
    chk("ld_rdata", d_rdata, 32'h12345678);

    // Alternating fetch/data loads: one response per cycle after the first.
    nv = 0; ni = 0; nd = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 16)         cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
      else if (k % 2 == 0) cyc(1'b0, 1'b1, 10'(32'h30 + k), 1'b0, 1'b0, 10'h000, 32'd0);
      else                 cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'(32'h40 + k), 32'd0);
      if (k > 0 && (i_rvalid ^ d_rvalid)) nv++;
      if (i_rvalid) ni++;
      if (d_rvalid) nd++;
    end
    chk("alt_one_per_cycle", 32'(nv), 32'd16);
    chk("alt_fetch_count", 32'(ni), 32'd8);
    chk("alt_data_count", 32'(nd), 32'd8);

    // Both requesting continuously.
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    ig = 12'd0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, 10'h060, 1'b1, 1'b0, 10'(32'h50 + k), 32'd0);
      ig[k] = i_gnt;
    end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    chk("starve_pattern", 32'(ig), 32'h210);
`else
    chk("starve_pattern", 32'(ig), 32'h000);
`endif
    cyc(1'b0, 1'b1, 10'h060, 1'b0, 1'b0, 10'h000, 32'd0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);

    // Reset arriving with a load outstanding.
    cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h007, 32'd0);
    chk("rl_gnt", 32'(d_gnt), 32'd1);
    cyc(1'b1, 1'b1, 10'h008, 1'b1, 1'b0, 10'h007, 32'd0);
    chk("rl_drop", 32'({d_rvalid, i_gnt, d_gnt, mem_en}), 32'd0);
    cyc(1'b1, 1'b1, 10'h008, 1'b1, 1'b0, 10'h007, 32'd0);
    chk("rl_hold", 32'({d_rvalid, i_rvalid, i_gnt, d_gnt}), 32'd0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("rl_after", 32'({d_rvalid, i_rvalid}), 32'd0);
    cyc(1'b0, 1'b1, 10'h009, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("rl_fetch_gnt", 32'(i_gnt), 32'd1);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'd0);
    chk("rl_fetch_rdata", i_rdata, 32'h5A000009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
